liang_mem_arbiter: RTL and testbench
====================================

# liang_mem_arbiter

Two-requester memory-port arbiter for the liang core. Shares one 32-bit valid/ready memory port between the IFU (instruction fetch) and the LSU (load/store), and sequences each transaction through request, accept and response phases. Exactly one transaction is outstanding at a time, and each response is routed back to the requester that issued it. Sits between the IF/EX stages and the memory/bus bridge.

## Interface
- ADDR_WIDTH, 32, address width; matches package ADDR_WIDTH
- DATA_WIDTH, 32, data width; STRB_WIDTH = DATA_WIDTH/8
- clk  in  1  core clock
- rst_n  in  1  reset, asynchronous, active-low
- ifu_req_valid  in  1  IFU fetch request
- ifu_req_ready  out  1  IFU request accepted this cycle
- ifu_req_addr  in  ADDR_WIDTH  fetch address (pc_t)
- ifu_rsp_valid  out  1  fetch data valid, one-cycle pulse
- ifu_rsp_rdata  out  DATA_WIDTH  fetched instruction
- lsu_req_valid  in  1  LSU request
- lsu_req_ready  out  1  LSU request accepted this cycle
- lsu_req_addr  in  ADDR_WIDTH  load/store address (paddr_t)
- lsu_req_wen  in  1  1 = store, 0 = load
- lsu_req_wdata  in  DATA_WIDTH  store data
- lsu_req_wstrb  in  STRB_WIDTH  store byte strobes
- lsu_rsp_valid  out  1  load data or store acknowledge, one-cycle pulse
- lsu_rsp_rdata  out  DATA_WIDTH  load data (raw word; no extension applied)
- mem_req_valid  out  1  memory request
- mem_req_ready  in  1  memory accepts request
- mem_req_addr / mem_req_wen / mem_req_wdata / mem_req_wstrb  out  ADDR_WIDTH/1/DATA_WIDTH/STRB_WIDTH  captured request fields
- mem_rsp_valid  in  1  memory response; required for both reads and writes
- mem_rsp_rdata  in  DATA_WIDTH  read data

## Operation
- FSM states: IDLE, REQ, WAIT; reset state is IDLE.
- IDLE:
  - If any `*_req_valid` is high, pick a winner and assert that requester's `*_req_ready` combinationally in the same cycle.
  - Capture addr, wen, wdata and wstrb into internal registers, and set owner = winner. Go to REQ.
  - IFU requests are captured with wen=0, wdata=0, wstrb=0.
- REQ:
  - `mem_req_valid`=1 and the `mem_req_*` outputs show the captured fields.
  - Fields stay stable until `mem_req_ready`. On `mem_req_valid && mem_req_ready`, go to WAIT.
- WAIT:
  - On `mem_rsp_valid`, pulse `<owner>_rsp_valid`=1 for that cycle. `<owner>_rsp_rdata` = `mem_rsp_rdata`, passed through combinationally. Go to IDLE.
- Both `*_req_ready` outputs are 0 outside IDLE.
- Outside WAIT, `*_rsp_valid` = 0 and `*_rsp_rdata` = 0.
- In IDLE and REQ, `mem_rsp_valid` is ignored and nothing is forwarded.
- Ties (both requests valid in IDLE): resolved per Configuration.
- A single requesting source is always granted, regardless of arbitration mode.

## Timing
- Reset values: `ifu_req_ready`=0, `lsu_req_ready`=0, `ifu_rsp_valid`=0, `lsu_rsp_valid`=0, both `rsp_rdata`=0, `mem_req_valid`=0, all `mem_req_*` fields=0; owner=IFU, last_grant=IFU.
- Accept happens in cycle N (IDLE). `mem_req_valid` first rises in cycle N+1.
- With memory ready immediately and a response one cycle later, the response returns in cycle N+2 and the next accept is possible in N+3. Minimum occupancy is 3 cycles per transaction.
- The memory must not return a response in the same cycle it accepts a request. A response is valid only in WAIT.
- Requesters hold valid and fields until their ready is seen; the arbiter samples fields only on the accept cycle.
- Reset asserted mid-transaction: immediate return to IDLE and all outputs go to reset values. Any late `mem_rsp_valid` arriving after reset is dropped.
- No combinational path from `mem_req_ready` to any requester ready.

## Configuration
- `LIANG_ARB_RR_EN` defined:
  - Ties are round-robin: grant the requester that was not granted last.
  - last_grant is updated on every accept and resets to IFU, so the first tie goes to LSU.
- Undefined: fixed priority, LSU always wins ties. LSU is older in program order, which avoids a fetch-blocks-load deadlock. The last_grant register is not built.

## Test plan
- Single IFU fetch:
  - Stimulus: `ifu_req_addr`=0x80000000; memory ready at once; response rdata=0x00100073 one cycle later.
  - Required: `ifu_req_ready` in cycle 0, `mem_req_valid` in cycle 1, `ifu_rsp_valid` with 0x00100073 in cycle 2, `lsu_rsp_valid` stays 0.
- LSU store with stalled memory:
  - Stimulus: addr 0x80001004, wdata 0xDEADBEEF, wstrb 4'b1100; `mem_req_ready` low for 3 cycles.
  - Required: `mem_req_*` fields stable for those 3 cycles, then the ack pulses `lsu_rsp_valid` exactly once.
- Tie, fixed priority (macro off):
  - Stimulus: both requesters valid continuously for 3 transactions.
  - Required: LSU granted 3 times and IFU only after `lsu_req_valid` drops.
- Tie, round-robin (macro on):
  - Stimulus: both requesters valid continuously for 4 transactions.
  - Required: grant order LSU, IFU, LSU, IFU; every response goes to the matching owner.
- Spurious and reset cases:
  - Stimulus: `mem_rsp_valid` pulsed in IDLE.
  - Required: no `rsp_valid` pulse on either requester.
  - Stimulus: `rst_n` asserted in WAIT, then the memory response arrives after reset release.
  - Required: outputs return to reset values and the late response is dropped.

Source files
------------

// File: rtl/liang_mem_arbiter_if.sv
// Bundle of the IFU, LSU and memory-side request/response signals around the
// liang memory-port arbiter; "master" is the arbiter's view, "slave" is the environment's.
interface liang_mem_arbiter_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
);
    localparam int STRB_WIDTH = DATA_WIDTH / 8;

    logic                  ifu_req_valid;
    logic                  ifu_req_ready;
    logic [ADDR_WIDTH-1:0] ifu_req_addr;
    logic                  ifu_rsp_valid;
    logic [DATA_WIDTH-1:0] ifu_rsp_rdata;

    logic                  lsu_req_valid;
    logic                  lsu_req_ready;
    logic [ADDR_WIDTH-1:0] lsu_req_addr;
    logic                  lsu_req_wen;
    logic [DATA_WIDTH-1:0] lsu_req_wdata;
    logic [STRB_WIDTH-1:0] lsu_req_wstrb;
    logic                  lsu_rsp_valid;
    logic [DATA_WIDTH-1:0] lsu_rsp_rdata;

    logic                  mem_req_valid;
    logic                  mem_req_ready;
    logic [ADDR_WIDTH-1:0] mem_req_addr;
    logic                  mem_req_wen;
    logic [DATA_WIDTH-1:0] mem_req_wdata;
    logic [STRB_WIDTH-1:0] mem_req_wstrb;
    logic                  mem_rsp_valid;
    logic [DATA_WIDTH-1:0] mem_rsp_rdata;

    modport master (
        input  ifu_req_valid, ifu_req_addr,
        output ifu_req_ready, ifu_rsp_valid, ifu_rsp_rdata,
        input  lsu_req_valid, lsu_req_addr, lsu_req_wen, lsu_req_wdata, lsu_req_wstrb,
        output lsu_req_ready, lsu_rsp_valid, lsu_rsp_rdata,
        output mem_req_valid, mem_req_addr, mem_req_wen, mem_req_wdata, mem_req_wstrb,
        input  mem_req_ready, mem_rsp_valid, mem_rsp_rdata
    );

    modport slave (
        output ifu_req_valid, ifu_req_addr,
        input  ifu_req_ready, ifu_rsp_valid, ifu_rsp_rdata,
        output lsu_req_valid, lsu_req_addr, lsu_req_wen, lsu_req_wdata, lsu_req_wstrb,
        input  lsu_req_ready, lsu_rsp_valid, lsu_rsp_rdata,
        input  mem_req_valid, mem_req_addr, mem_req_wen, mem_req_wdata, mem_req_wstrb,
        output mem_req_ready, mem_rsp_valid, mem_rsp_rdata
    );
endinterface

// File: rtl/liang_mem_arbiter.sv
// IFU/LSU arbiter for the single liang memory port: one outstanding transaction, response routed to its owner.
// Define LIANG_ARB_RR_EN for round-robin ties; otherwise the LSU always wins ties.
module liang_mem_arbiter #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
) (
    input  logic                clk,
    input  logic                rst_n,
    liang_mem_arbiter_if.master bus
);
    localparam int STRB_WIDTH = DATA_WIDTH / 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2
    } state_t;

    state_t                state;
    logic                  owner_lsu;
    logic                  vld_p0;
    logic [ADDR_WIDTH-1:0] addr_p0;
    logic                  wen_p0;
    logic [DATA_WIDTH-1:0] wdata_p0;
    logic [STRB_WIDTH-1:0] wstrb_p0;

    logic accept_en;
    logic tie_lsu;
    logic grant_lsu;
    logic grant_ifu;
    logic rsp_fire;

`ifdef LIANG_ARB_RR_EN
    logic last_grant_lsu;
    assign tie_lsu = !last_grant_lsu;
`else
    // The LSU is older in program order; favouring it keeps a fetch from starving a load.
    assign tie_lsu = 1'b1;
`endif

    // Grants depend only on registered state and request valids, never on mem_req_ready.
    assign accept_en = (state == IDLE) && rst_n;
    assign grant_lsu = accept_en && bus.lsu_req_valid && (!bus.ifu_req_valid || tie_lsu);
    assign grant_ifu = accept_en && bus.ifu_req_valid && !(bus.lsu_req_valid && tie_lsu);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            owner_lsu <= 1'b0;
            vld_p0    <= 1'b0;
            addr_p0   <= '0;
            wen_p0    <= 1'b0;
            wdata_p0  <= '0;
            wstrb_p0  <= '0;
`ifdef LIANG_ARB_RR_EN
            last_grant_lsu <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (grant_lsu || grant_ifu) begin
                        state     <= REQ;
                        vld_p0    <= 1'b1;
                        owner_lsu <= grant_lsu;
`ifdef LIANG_ARB_RR_EN
                        last_grant_lsu <= grant_lsu;
`endif
                        if (grant_lsu) begin
                            addr_p0  <= bus.lsu_req_addr;
                            wen_p0   <= bus.lsu_req_wen;
                            wdata_p0 <= bus.lsu_req_wdata;
                            wstrb_p0 <= bus.lsu_req_wstrb;
                        end else begin
                            addr_p0  <= bus.ifu_req_addr;
                            wen_p0   <= 1'b0;
                            wdata_p0 <= '0;
                            wstrb_p0 <= '0;
                        end
                    end
                end
                REQ: begin
                    if (bus.mem_req_ready) begin
                        state  <= WAIT;
                        vld_p0 <= 1'b0;
                    end
                end
                WAIT: begin
                    if (bus.mem_rsp_valid) begin
                        state <= IDLE;
                    end
                end
                default: begin
                    state  <= IDLE;
                    vld_p0 <= 1'b0;
                end
            endcase
        end
    end

    assign bus.ifu_req_ready = grant_ifu;
    assign bus.lsu_req_ready = grant_lsu;

    assign bus.mem_req_valid = vld_p0;
    assign bus.mem_req_addr  = addr_p0;
    assign bus.mem_req_wen   = wen_p0;
    assign bus.mem_req_wdata = wdata_p0;
    assign bus.mem_req_wstrb = wstrb_p0;

    // Responses are forwarded only while waiting; stray responses in IDLE/REQ vanish here.
    assign rsp_fire          = (state == WAIT) && bus.mem_rsp_valid;
    assign bus.ifu_rsp_valid = rsp_fire && !owner_lsu;
    assign bus.lsu_rsp_valid = rsp_fire && owner_lsu;
    assign bus.ifu_rsp_rdata = ((state == WAIT) && !owner_lsu) ? bus.mem_rsp_rdata : '0;
    assign bus.lsu_rsp_rdata = ((state == WAIT) && owner_lsu) ? bus.mem_rsp_rdata : '0;
endmodule

// File: tb/tb_liang_mem_arbiter.sv
// Directed bench for liang_mem_arbiter; tie expectations follow LIANG_ARB_RR_EN.
module tb_liang_mem_arbiter;
    logic clk;
    logic rst_n;
    int   checks;
    int   errors;

    liang_mem_arbiter_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) bus ();

    liang_mem_arbiter #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.master)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic quiet_inputs();
        bus.ifu_req_valid = 1'b0;
        bus.ifu_req_addr  = '0;
        bus.lsu_req_valid = 1'b0;
        bus.lsu_req_addr  = '0;
        bus.lsu_req_wen   = 1'b0;
        bus.lsu_req_wdata = '0;
        bus.lsu_req_wstrb = '0;
        bus.mem_req_ready = 1'b0;
        bus.mem_rsp_valid = 1'b0;
        bus.mem_rsp_rdata = '0;
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        quiet_inputs();
        bus.ifu_req_valid = 1'b1;
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        checks++;
        if ({bus.ifu_req_ready, bus.lsu_req_ready, bus.ifu_rsp_valid, bus.lsu_rsp_valid,
             bus.mem_req_valid, bus.mem_req_wen} !== 6'b0) begin
            errors++;
            $display("FAIL reset_ctrl: got %b expected 000000", {bus.ifu_req_ready, bus.lsu_req_ready,
                     bus.ifu_rsp_valid, bus.lsu_rsp_valid, bus.mem_req_valid, bus.mem_req_wen});
        end
        checks++;
        if ({bus.mem_req_addr, bus.mem_req_wdata, bus.mem_req_wstrb, bus.ifu_rsp_rdata, bus.lsu_rsp_rdata} !== '0) begin
            errors++;
            $display("FAIL reset_data: addr=%h wdata=%h wstrb=%h ifu_rd=%h lsu_rd=%h expected all 0",
                     bus.mem_req_addr, bus.mem_req_wdata, bus.mem_req_wstrb, bus.ifu_rsp_rdata, bus.lsu_rsp_rdata);
        end
        bus.ifu_req_valid = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    task automatic test_ifu_fetch();
        bus.ifu_req_valid = 1'b1;
        bus.ifu_req_addr  = 32'h8000_0000;
        bus.mem_req_ready = 1'b1;
        @(negedge clk);
        checks++;
        if ({bus.ifu_req_ready, bus.lsu_req_ready, bus.mem_req_valid} !== 3'b100) begin
            errors++;
            $display("FAIL fetch_accept: got ifu/lsu ready,mem_valid=%b expected 100",
                     {bus.ifu_req_ready, bus.lsu_req_ready, bus.mem_req_valid});
        end
        next_cycle();
        bus.ifu_req_valid = 1'b0;
        bus.ifu_req_addr  = 32'h1234_5678;
        @(negedge clk);
        checks++;
        if ({bus.mem_req_valid, bus.mem_req_addr, bus.mem_req_wen, bus.mem_req_wdata, bus.mem_req_wstrb}
            !== {1'b1, 32'h8000_0000, 1'b0, 32'h0, 4'h0}) begin
            errors++;
            $display("FAIL fetch_req: got valid=%b addr=%h wen=%b wdata=%h wstrb=%h expected 1 80000000 0 0 0",
                     bus.mem_req_valid, bus.mem_req_addr, bus.mem_req_wen, bus.mem_req_wdata, bus.mem_req_wstrb);
        end
        next_cycle();
        bus.mem_rsp_valid = 1'b1;
        bus.mem_rsp_rdata = 32'h0010_0073;
        @(negedge clk);
        checks++;
        if ({bus.ifu_rsp_valid, bus.lsu_rsp_valid, bus.ifu_rsp_rdata, bus.lsu_rsp_rdata}
            !== {1'b1, 1'b0, 32'h0010_0073, 32'h0}) begin
            errors++;
            $display("FAIL fetch_rsp: got ifu_v=%b lsu_v=%b ifu_rd=%h lsu_rd=%h expected 1 0 00100073 0",
                     bus.ifu_rsp_valid, bus.lsu_rsp_valid, bus.ifu_rsp_rdata, bus.lsu_rsp_rdata);
        end
        next_cycle();
        bus.mem_rsp_valid = 1'b0;
        bus.mem_rsp_rdata = '0;
        bus.mem_req_ready = 1'b0;
        @(negedge clk);
        checks++;
        if ({bus.ifu_rsp_valid, bus.mem_req_valid} !== 2'b00) begin
            errors++;
            $display("FAIL fetch_done: got ifu_v,mem_valid=%b expected 00", {bus.ifu_rsp_valid, bus.mem_req_valid});
        end
        next_cycle();
    endtask

    task automatic test_lsu_store_stall();
        int lsu_pulses;
        int ifu_pulses;
        lsu_pulses = 0;
        ifu_pulses = 0;
        bus.lsu_req_valid = 1'b1;
        bus.lsu_req_addr  = 32'h8000_1004;
        bus.lsu_req_wen   = 1'b1;
        bus.lsu_req_wdata = 32'hDEAD_BEEF;
        bus.lsu_req_wstrb = 4'b1100;
        bus.mem_req_ready = 1'b0;
        @(negedge clk);
        checks++;
        if ({bus.ifu_req_ready, bus.lsu_req_ready} !== 2'b01) begin
            errors++;
            $display("FAIL store_accept: got ifu/lsu ready=%b expected 01", {bus.ifu_req_ready, bus.lsu_req_ready});
        end
        for (int c = 1; c <= 8; c++) begin
            next_cycle();
            bus.lsu_req_valid = 1'b0;
            bus.lsu_req_addr  = 32'hFFFF_FFF0;
            bus.lsu_req_wdata = 32'h0BAD_F00D;
            bus.lsu_req_wstrb = 4'b0011;
            bus.mem_req_ready = (c == 4);
            bus.mem_rsp_valid = (c == 1) || (c == 6);
            bus.mem_rsp_rdata = (c == 6) ? 32'h1234_5678 : 32'h5555_AAAA;
            @(negedge clk);
            if (bus.lsu_rsp_valid === 1'b1) lsu_pulses++;
            if (bus.ifu_rsp_valid === 1'b1) ifu_pulses++;
            if (c <= 4) begin
                checks++;
                if ({bus.mem_req_valid, bus.mem_req_addr, bus.mem_req_wen, bus.mem_req_wdata, bus.mem_req_wstrb}
                    !== {1'b1, 32'h8000_1004, 1'b1, 32'hDEAD_BEEF, 4'b1100}) begin
                    errors++;
                    $display("FAIL store_stable_c%0d: got valid=%b addr=%h wen=%b wdata=%h wstrb=%b expected 1 80001004 1 deadbeef 1100",
                             c, bus.mem_req_valid, bus.mem_req_addr, bus.mem_req_wen, bus.mem_req_wdata, bus.mem_req_wstrb);
                end
            end
            if (c == 6) begin
                checks++;
                if ({bus.lsu_rsp_valid, bus.lsu_rsp_rdata} !== {1'b1, 32'h1234_5678}) begin
                    errors++;
                    $display("FAIL store_ack: got lsu_v=%b lsu_rd=%h expected 1 12345678", bus.lsu_rsp_valid, bus.lsu_rsp_rdata);
                end
            end
        end
        checks++;
        if (lsu_pulses !== 1 || ifu_pulses !== 0) begin
            errors++;
            $display("FAIL store_pulses: got lsu=%0d ifu=%0d expected lsu=1 ifu=0", lsu_pulses, ifu_pulses);
        end
        quiet_inputs();
        next_cycle();
    endtask

    task automatic test_tie();
        logic exp_lsu;
        logic lsu_on;
        int   k;
        test_reset();
        bus.ifu_req_addr  = 32'h0000_0100;
        bus.lsu_req_addr  = 32'h0000_0200;
        bus.lsu_req_wen   = 1'b0;
        bus.mem_req_ready = 1'b1;
        for (int c = 0; c < 12; c++) begin
            k = c / 3;
`ifdef LIANG_ARB_RR_EN
            exp_lsu = (k % 2 == 0);
            lsu_on  = 1'b1;
`else
            exp_lsu = (k < 3);
            lsu_on  = (c < 9);
`endif
            bus.ifu_req_valid = 1'b1;
            bus.lsu_req_valid = lsu_on;
            bus.mem_rsp_valid = (c % 3 == 2);
            bus.mem_rsp_rdata = 32'hA0 + 32'(k);
            @(negedge clk);
            checks++;
            if (c % 3 == 0) begin
                if ({bus.ifu_req_ready, bus.lsu_req_ready} !== {!exp_lsu, exp_lsu}) begin
                    errors++;
                    $display("FAIL tie_grant_%0d: got ifu/lsu ready=%b expected %b", k,
                             {bus.ifu_req_ready, bus.lsu_req_ready}, {!exp_lsu, exp_lsu});
                end
            end else if (c % 3 == 1) begin
                if ({bus.mem_req_valid, bus.mem_req_addr} !== {1'b1, (exp_lsu ? 32'h200 : 32'h100)}) begin
                    errors++;
                    $display("FAIL tie_addr_%0d: got valid=%b addr=%h expected 1 %h", k,
                             bus.mem_req_valid, bus.mem_req_addr, (exp_lsu ? 32'h200 : 32'h100));
                end
            end else begin
                if ({bus.ifu_rsp_valid, bus.lsu_rsp_valid, bus.ifu_rsp_rdata, bus.lsu_rsp_rdata} !==
                    {!exp_lsu, exp_lsu, (exp_lsu ? 32'h0 : 32'hA0 + 32'(k)), (exp_lsu ? 32'hA0 + 32'(k) : 32'h0)}) begin
                    errors++;
                    $display("FAIL tie_rsp_%0d: got ifu_v=%b lsu_v=%b ifu_rd=%h lsu_rd=%h expected owner lsu=%b data=%h",
                             k, bus.ifu_rsp_valid, bus.lsu_rsp_valid, bus.ifu_rsp_rdata, bus.lsu_rsp_rdata,
                             exp_lsu, 32'hA0 + 32'(k));
                end
            end
            next_cycle();
        end
        quiet_inputs();
        next_cycle();
    endtask

    task automatic test_spurious_idle();
        for (int c = 0; c < 2; c++) begin
            bus.mem_rsp_valid = 1'b1;
            bus.mem_rsp_rdata = 32'hCAFE_0000 + 32'(c);
            @(negedge clk);
            checks++;
            if ({bus.ifu_rsp_valid, bus.lsu_rsp_valid, bus.ifu_rsp_rdata, bus.lsu_rsp_rdata, bus.mem_req_valid} !== '0) begin
                errors++;
                $display("FAIL spurious_idle_%0d: got ifu_v=%b lsu_v=%b ifu_rd=%h lsu_rd=%h mem_v=%b expected all 0", c,
                         bus.ifu_rsp_valid, bus.lsu_rsp_valid, bus.ifu_rsp_rdata, bus.lsu_rsp_rdata, bus.mem_req_valid);
            end
            next_cycle();
        end
        quiet_inputs();
    endtask

    task automatic test_reset_in_wait();
        bus.lsu_req_valid = 1'b1;
        bus.lsu_req_addr  = 32'h8000_2000;
        bus.lsu_req_wen   = 1'b1;
        bus.lsu_req_wdata = 32'h0102_0304;
        bus.lsu_req_wstrb = 4'hF;
        bus.mem_req_ready = 1'b1;
        next_cycle();
        bus.lsu_req_valid = 1'b0;
        next_cycle();
        bus.mem_req_ready = 1'b0;
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        checks++;
        if ({bus.ifu_req_ready, bus.lsu_req_ready, bus.ifu_rsp_valid, bus.lsu_rsp_valid, bus.mem_req_valid,
             bus.mem_req_wen, bus.mem_req_addr, bus.mem_req_wdata, bus.mem_req_wstrb} !== '0) begin
            errors++;
            $display("FAIL reset_wait_outputs: got mem_v=%b addr=%h wen=%b wdata=%h wstrb=%h expected all 0",
                     bus.mem_req_valid, bus.mem_req_addr, bus.mem_req_wen, bus.mem_req_wdata, bus.mem_req_wstrb);
        end
        next_cycle();
        rst_n = 1'b1;
        next_cycle();
        bus.mem_rsp_valid = 1'b1;
        bus.mem_rsp_rdata = 32'hBADB_AD00;
        @(negedge clk);
        checks++;
        if ({bus.ifu_rsp_valid, bus.lsu_rsp_valid, bus.ifu_rsp_rdata, bus.lsu_rsp_rdata, bus.mem_req_valid} !== '0) begin
            errors++;
            $display("FAIL late_rsp_dropped: got ifu_v=%b lsu_v=%b ifu_rd=%h lsu_rd=%h mem_v=%b expected all 0",
                     bus.ifu_rsp_valid, bus.lsu_rsp_valid, bus.ifu_rsp_rdata, bus.lsu_rsp_rdata, bus.mem_req_valid);
        end
        next_cycle();
        bus.mem_rsp_valid = 1'b0;
        bus.ifu_req_valid = 1'b1;
        bus.ifu_req_addr  = 32'h8000_0040;
        @(negedge clk);
        checks++;
        if ({bus.ifu_req_ready, bus.lsu_req_ready} !== 2'b10) begin
            errors++;
            $display("FAIL post_reset_accept: got ifu/lsu ready=%b expected 10", {bus.ifu_req_ready, bus.lsu_req_ready});
        end
        next_cycle();
        quiet_inputs();
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst_n  = 1'b0;
        quiet_inputs();
        test_reset();
        test_ifu_fetch();
        test_lsu_store_stall();
        test_spurious_idle();
        test_tie();
        test_reset_in_wait();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
